// File: rtl/seq_multiplier_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// seq_multiplier_if
// Request/result bundle between pipeline control and the sequential
// multiplier.
//   start     : request strobe, sampled on the rising clock edge
//   signal    : 6-bit function code (MULT / MULTU)
//   src_a     : multiplicand (rs value)
//   src_b     : multiplier (rt value)
//   multi_out : registered 2*WIDTH product feeding HI/LO
//   busy      : high while a multiply is in flight
//   done      : one-cycle pulse when multi_out has just been updated
// Modports: master = requester (pipeline control), slave = multiplier.
// ---------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [5:0]           signal;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic [2*WIDTH-1:0]   multi_out;
  logic                 busy;
  logic                 done;

  modport master (
    output start, signal, src_a, src_b,
    input  multi_out, busy, done
  );

  modport slave (
    input  start, signal, src_a, src_b,
    output multi_out, busy, done
  );
endinterface

// File: rtl/seq_multiplier.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// seq_multiplier
// Multi-cycle shift-add multiplier for MULT (signed) and MULTU (unsigned).
// Drives the HI/LO register, which samples multi_out every clock, so
// multi_out only changes when a product completes (or on reset).
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : seq_multiplier_if.slave (start, signal, src_a, src_b in;
//           multi_out, busy, done out)
//
// Configuration macro:
//   MULT_RADIX4_EN : when defined, retires two multiplier bits per cycle
//                    (latency WIDTH/2); otherwise one bit per cycle
//                    (latency WIDTH).
//
// Signed multiplies run on magnitudes and negate the final product when the
// operand signs differ; the most negative operand's magnitude is still
// representable as an unsigned WIDTH-bit value.
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int         WIDTH       = 32,
  parameter logic [5:0] FUNCT_MULT  = 6'd24,
  parameter logic [5:0] FUNCT_MULTU = 6'd25
) (
  input  logic              clk,
  input  logic              reset,
  seq_multiplier_if.slave   bus
);

`ifdef MULT_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int STEPS = WIDTH / STEP;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplr;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CW-1:0]        counter;
  logic [2*WIDTH-1:0]   multi_out_q;

  logic                 is_mult;
  logic                 sig_ok;
  logic                 accept;
  logic                 last;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH+STEP-1:0] addend;
  logic [WIDTH+STEP-1:0] hi_sum;

  assign is_mult = (bus.signal == FUNCT_MULT);
  assign sig_ok  = is_mult || (bus.signal == FUNCT_MULTU);
  // A request in RUN is dropped; DONE can accept for back-to-back issue.
  assign accept  = bus.start && sig_ok && (state != RUN);
  assign last    = (state == RUN) && (counter == CW'(STEPS - 1));

  assign a_mag = (is_mult && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign b_mag = (is_mult && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0] mcand3;

  always_comb begin
    unique case (mplr[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, mcand};
      2'd2:    addend = {1'b0, mcand, 1'b0};
      default: addend = mcand3;
    endcase
  end
`else
  assign addend = mplr[0] ? {1'b0, mcand} : '0;
`endif

  // Add into the upper half with the carry kept, then shift the whole
  // accumulator right by the number of bits retired this cycle.
  assign hi_sum   = {{STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]} + addend;
  assign acc_next = {hi_sum, acc[WIDTH-1:STEP]};

  // NOTE: state register and next-state logic are split; the always_comb
  // assigns state_next a default first so no path can infer a latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all datapath registers use non-blocking assignments so every
  // register samples the pre-edge values computed by the combinational logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand       <= '0;
      mplr        <= '0;
      neg         <= 1'b0;
      acc         <= '0;
      counter     <= '0;
      multi_out_q <= '0;
`ifdef MULT_RADIX4_EN
      mcand3      <= '0;
`endif
    end else if (accept) begin
      mcand   <= a_mag;
      mplr    <= b_mag;
      neg     <= is_mult && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
      acc     <= '0;
      counter <= '0;
`ifdef MULT_RADIX4_EN
      mcand3  <= {2'b00, a_mag} + {1'b0, a_mag, 1'b0};
`endif
    end else if (state == RUN) begin
      acc     <= acc_next;
      mplr    <= mplr >> STEP;
      counter <= counter + CW'(1);
      if (last) multi_out_q <= neg ? -acc_next : acc_next;
    end
  end

  assign bus.multi_out = multi_out_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Directed bench for seq_multiplier. A cycle-level behavioural model
// (product computed with plain 64-bit arithmetic, completion after a fixed
// latency) is compared against busy/done/multi_out on every falling edge;
// literal products pin the model for each directed vector.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;
  localparam int W = 32;
`ifdef MULT_RADIX4_EN
  localparam int LAT = W / 2;
`else
  localparam int LAT = W;
`endif
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(W)) mul_if ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mul_if)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] product(input logic [5:0] sig,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb;
    if (sig == F_MULT) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end else begin
      ea = {32'b0, a};
      eb = {32'b0, b};
    end
    return ea * eb;
  endfunction

  // Behavioural model: an accepted request completes LAT edges later.
  logic [63:0] m_out, m_pend;
  logic        m_busy, m_done;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out  <= '0;
      m_pend <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_out  <= m_pend;
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      if (mul_if.start && (mul_if.signal == F_MULT || mul_if.signal == F_MULTU)) begin
        m_pend <= product(mul_if.signal, mul_if.src_a, mul_if.src_b);
        m_left <= LAT;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("busy",      64'(mul_if.busy), 64'(m_busy));
      check("done",      64'(mul_if.done), 64'(m_done));
      check("multi_out", mul_if.multi_out, m_out);
    end
  end

  task automatic start_op(input logic [5:0] sig, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    mul_if.start  = 1'b1;
    mul_if.signal = sig;
    mul_if.src_a  = a;
    mul_if.src_b  = b;
    @(negedge clk);
    // Scramble inputs while busy; the result must not depend on them.
    mul_if.start  = 1'b0;
    mul_if.signal = 6'd0;
    mul_if.src_a  = ~a;
    mul_if.src_b  = a ^ b;
  endtask

  task automatic wait_done(output int n);
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < LAT + 8) begin
      @(negedge clk);
      n++;
      found = mul_if.done;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles at %0t", n, $time);
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] sig,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int n;
    start_op(sig, a, b);
    wait_done(n);
    check({name, "_latency"}, 64'(n), 64'(LAT));
    check(name, mul_if.multi_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mul_if.start  = 1'b0;
    mul_if.signal = 6'd0;
    mul_if.src_a  = '0;
    mul_if.src_b  = '0;
    #1 reset = 1'b1;
    #21 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out",  mul_if.multi_out, 64'h0);
    check("rst_busy", 64'(mul_if.busy), 64'h0);
    check("rst_done", 64'(mul_if.done), 64'h0);

    // Unsigned max * max
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    // Signed cases and unsigned MSB case
    run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_minxmin", F_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("multu_msbx2", F_MULTU, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    run_op("mult_7xneg9", F_MULT, 32'd7, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFC1);

    // Start during RUN is ignored
    start_op(F_MULTU, 32'd7, 32'd9);
    repeat (4) @(negedge clk);
    mul_if.start  = 1'b1;
    mul_if.signal = F_MULTU;
    mul_if.src_a  = 32'd5;
    mul_if.src_b  = 32'd5;
    @(negedge clk);
    mul_if.start  = 1'b0;
    wait_done(n);
    check("run_ignore", mul_if.multi_out, 64'd63);

    // Unsupported function code in IDLE is ignored
    repeat (2) @(negedge clk);
    mul_if.start  = 1'b1;
    mul_if.signal = 6'd16;
    @(negedge clk);
    mul_if.start  = 1'b0;
    repeat (3) @(negedge clk);
    check("badsig_busy", 64'(mul_if.busy), 64'h0);
    check("badsig_out",  mul_if.multi_out, 64'd63);

    // Asynchronous reset mid-run
    start_op(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_out",  mul_if.multi_out, 64'h0);
    check("arst_busy", 64'(mul_if.busy), 64'h0);
    check("arst_done", 64'(mul_if.done), 64'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    run_op("post_rst", F_MULTU, 32'd3, 32'd4, 64'h0000_0000_0000_000C);

    // Back-to-back: second request issued in the DONE cycle
    start_op(F_MULTU, 32'd2, 32'd3);
    wait_done(n);
    check("b2b_first", mul_if.multi_out, 64'd6);
    mul_if.start  = 1'b1;
    mul_if.signal = F_MULTU;
    mul_if.src_a  = 32'd4;
    mul_if.src_b  = 32'd5;
    @(negedge clk);
    mul_if.start  = 1'b0;
    check("b2b_busy", 64'(mul_if.busy), 64'h1);
    check("b2b_hold", mul_if.multi_out, 64'd6);
    wait_done(n);
    check("b2b_latency", 64'(n), 64'(LAT));
    check("b2b_second", mul_if.multi_out, 64'd20);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
